sw_debounce_sync: RTL and testbench

//   Input conditioner for the board slide switches. Sits directly upstream of the

---
 rtl/sw_debounce_sync_pkg.sv | 28 ++
 rtl/sw_db_bit.sv | 87 ++++++++
 rtl/sw_debounce_sync.sv | 39 +++
 tb/tb_sw_debounce_sync.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_sync_pkg.sv
// Shared definitions for the slide-switch conditioner: default debounce
// window, switch count and the per-bit debounce state encoding.
package sw_debounce_sync_pkg;

  // 10 ms hold window at a 50 MHz system clock.
  localparam int DB_CYCLES_DEFAULT = 500000;

  // Four board slide switches feed SW1..SW4 of the adder/subtractor stage.
  localparam int NSW_DEFAULT = 4;

  // IDLE: synchronised level agrees with the debounced output.
  // COUNT: a different level is being timed for acceptance.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_t;

  // Counter width for a window of db_cycles. The counter only has to hold
  // values up to db_cycles-1, so $clog2 is enough; clamp so a degenerate
  // window still yields a legal one-bit counter.
  function automatic int cnt_width(input int db_cycles);
    if (db_cycles <= 2) begin
      return 1;
    end
    return $clog2(db_cycles);
  endfunction

endpackage

// File: rtl/sw_db_bit.sv
// Single-switch conditioner: two-flop synchroniser followed by a counter
// debounce. Produces a clean level plus one-cycle rise/fall pulses, and
// flags when a candidate level change is being timed.
module sw_db_bit
  import sw_debounce_sync_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_out,
  output logic sw_rise,
  output logic sw_fall,
  output logic busy
);

  localparam int CW = cnt_width(DB_CYCLES);

  // Last count value: the candidate level has been seen on DB_CYCLES
  // consecutive cycles once the counter sits here and the level still differs.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1;
  logic          s2;
  db_state_t     state;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clock domain; only s2 is trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Debounce FSM: any return to the accepted level restarts the window,
  // so a change is only taken after an unbroken run of DB_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sw_out  <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      case (state)
        IDLE: begin
          if (s2 != sw_out) begin
            state <= COUNT;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        COUNT: begin
          if (s2 == sw_out) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            sw_out  <= s2;
            sw_rise <= s2;
            sw_fall <= ~s2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The state flop itself tells the outside world a change is pending.
  assign busy = (state == COUNT);

endmodule

// File: rtl/sw_debounce_sync.sv
// Input conditioner for the board slide switches. Each switch gets its own
// independent synchroniser and debouncer; the busy flags are combined so
// downstream logic can tell when any switch is still settling.
module sw_debounce_sync
  import sw_debounce_sync_pkg::*;
#(
  parameter int NSW       = NSW_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NSW-1:0] sw_raw,
  output logic [NSW-1:0] sw_out,
  output logic [NSW-1:0] sw_rise,
  output logic [NSW-1:0] sw_fall,
  output logic           busy
);

  logic [NSW-1:0] bit_busy;

  // One conditioner per switch; bit 0 drives SW1 through bit 3 driving SW4.
  for (genvar i = 0; i < NSW; i++) begin : g_bit
    sw_db_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_raw (sw_raw[i]),
      .sw_out (sw_out[i]),
      .sw_rise(sw_rise[i]),
      .sw_fall(sw_fall[i]),
      .busy   (bit_busy[i])
    );
  end

  // Each per-bit busy is a state flop, so this OR never sees sw_raw directly.
  assign busy = |bit_busy;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Self-checking bench for sw_debounce_sync with a short debounce window.
// A behavioural model states the acceptance rule directly: a bit flips once
// its synchronised samples have differed from the output for DB_CYCLES
// consecutive cycles. Directed scenarios pin the model with literal values,
// then randomised switch activity is compared against it every cycle.
module tb_sw_debounce_sync;

  localparam int NSW = 4;
  localparam int DB  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NSW-1:0] sw_raw;
  logic [NSW-1:0] sw_out;
  logic [NSW-1:0] sw_rise;
  logic [NSW-1:0] sw_fall;
  logic           busy;

  int checks = 0;
  int errors = 0;

  logic [NSW-1:0] mS1, mS2, mOut, mRise, mFall;
  logic           mBusy;
  bit             hist[NSW][$];

  sw_debounce_sync #(
    .NSW      (NSW),
    .DB_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .sw_out (sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .busy   (busy)
  );

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelClear();
    mS1 = '0; mS2 = '0; mOut = '0; mRise = '0; mFall = '0; mBusy = 1'b0;
    for (int i = 0; i < NSW; i++) hist[i].delete();
  endtask

  // Advance the model by one clock edge.
  task automatic modelStep();
    logic [NSW-1:0] samp;
    logic [NSW-1:0] newOut;
    bit             allDiff;
    if (!rst_n) begin
      modelClear();
    end else begin
      samp   = mS2;
      mS2    = mS1;
      mS1    = sw_raw;
      newOut = mOut;
      for (int i = 0; i < NSW; i++) begin
        hist[i].push_back(samp[i]);
        if (hist[i].size() > DB) void'(hist[i].pop_front());
        if (hist[i].size() == DB) begin
          allDiff = 1'b1;
          for (int k = 0; k < DB; k++) begin
            if (hist[i][k] == mOut[i]) allDiff = 1'b0;
          end
          if (allDiff) newOut[i] = ~mOut[i];
        end
      end
      mRise = newOut & ~mOut;
      mFall = ~newOut & mOut;
      mBusy = |(samp ^ newOut);
      mOut  = newOut;
    end
  endtask

  task automatic checkOutput();
    checkEq("sw_out", 32'(sw_out), 32'(mOut));
    checkEq("sw_rise", 32'(sw_rise), 32'(mRise));
    checkEq("sw_fall", 32'(sw_fall), 32'(mFall));
    checkEq("busy", 32'(busy), 32'(mBusy));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [NSW-1:0] v, input int n);
    sw_raw = v;
    repeat (n) tick();
  endtask

  // Asynchronous reset pulse landing between clock edges.
  task automatic doReset();
    rst_n = 1'b0;
    modelClear();
    #2;
    checkOutput();
    checkEq("reset out", 32'(sw_out), 32'h0);
    checkEq("reset busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_raw = '1;
    modelClear();

    // Reset held with all switches high
    repeat (3) tick();
    checkEq("rst sw_out", 32'(sw_out), 32'h0);
    checkEq("rst sw_rise", 32'(sw_rise), 32'h0);
    checkEq("rst sw_fall", 32'(sw_fall), 32'h0);
    checkEq("rst busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 8);

    // Clean step on bit 0
    applyStimulus(4'b0001, 5);
    checkEq("step early out", 32'(sw_out), 32'h0);
    tick();
    checkEq("step out", 32'(sw_out), 32'h1);
    checkEq("step rise", 32'(sw_rise), 32'h1);
    tick();
    checkEq("step rise gone", 32'(sw_rise), 32'h0);

    // Bounce on bit 1, then hold high
    applyStimulus(4'b0011, 1);
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0011, 1);
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0011, 5);
    checkEq("bounce early out", 32'(sw_out), 32'h1);
    tick();
    checkEq("bounce out", 32'(sw_out), 32'h3);
    checkEq("bounce rise", 32'(sw_rise), 32'h2);

    // Short glitch on bit 2
    applyStimulus(4'b0111, 3);
    checkEq("glitch busy", 32'(busy), 32'h1);
    applyStimulus(4'b0011, 10);
    checkEq("glitch out", 32'(sw_out), 32'h3);
    checkEq("glitch busy gone", 32'(busy), 32'h0);

    // Simultaneous change on all bits
    applyStimulus(4'b1100, 5);
    checkEq("simul early out", 32'(sw_out), 32'h3);
    tick();
    checkEq("simul out", 32'(sw_out), 32'hC);
    checkEq("simul rise", 32'(sw_rise), 32'hC);
    checkEq("simul fall", 32'(sw_fall), 32'h3);

    // Reset in the middle of a bit 3 rise
    applyStimulus(4'b0000, 10);
    checkEq("clear out", 32'(sw_out), 32'h0);
    applyStimulus(4'b1000, 3);
    checkEq("midcount busy", 32'(busy), 32'h1);
    doReset();
    repeat (5) tick();
    checkEq("requal early out", 32'(sw_out), 32'h0);
    tick();
    checkEq("requal out", 32'(sw_out), 32'h8);
    checkEq("requal rise", 32'(sw_rise), 32'h8);

    // Randomised switch activity with occasional resets
    for (int n = 0; n < 150; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 2 * DB + 2));
      if ($urandom_range(0, 29) == 0) doReset();
    end
    applyStimulus(sw_raw, 3 * DB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
